poly_eval_seq: RTL and testbench
================================

Name: poly_eval_seq

Overview:
- Parametrised sequential polynomial evaluator: y = a_D*x^D + ... + a_1*x + a_0, computed by Horner's method with one multiply-accumulate per cycle.
- Coefficients and x are entered one value per Go press/release on a shared DataIn bus; result is held with ResultValid.
- Generalises the fixed A*x^2+B*x+C lab datapath/control pair to any width and degree.
- Adds coefficient reuse, an overflow flag and a load-index indicator.
- Defaults (WIDTH=8, DEGREE=2) give exactly the A*x^2+B*x+C behaviour.

Parameters:
- WIDTH, 8, data, coefficient, x and result width in bits (>=2).
- DEGREE, 2, polynomial degree D (>=1); D+1 coefficients stored.
- IDXW, $clog2(DEGREE+2), width of LoadIndex (derived; do not override).

Ports:
- Clock  input  1  system clock, rising edge.
- Reset  input  1  synchronous, active-high reset.
- Go  input  1  level "value present / continue" strobe (debounced switch level).
- ReuseCoeffs  input  1  sampled on Go release in DONE_WAIT: 1 = load only a new x; 0 = reload all coefficients.
- DataIn  input  WIDTH  value being entered.
- DataResult  output  WIDTH  last completed result, unsigned, mod 2^WIDTH.
- ResultValid  output  1  high while DataResult holds a completed result (DONE, DONE_WAIT).
- Overflow  output  1  sticky: some Horner step of the last computation exceeded 2^WIDTH-1.
- Busy  output  1  high in INIT and STEP.
- LoadIndex  output  IDXW  value awaited: k while loading a_k; DEGREE+1 while loading x; 0 otherwise.

Behaviour:
- Reset (sync, highest priority, any state, including mid-computation):
  - state=LOAD_C, k=DEGREE.
  - All coefficient regs, x, acc, DataResult = 0; ResultValid=0, Overflow=0, Busy=0.
- Capture rule: a value is captured on the single clock edge where Go is sampled high in a LOAD state. The FSM then waits in the matching WAIT state until Go is sampled low. Holding Go high captures exactly once.
- States and transitions:
  - LOAD_C: Go=1 -> coef[k]<=DataIn, go to LOAD_C_WAIT.
  - LOAD_C_WAIT: Go=0 -> if k==0 go to LOAD_X, else k<=k-1 and go to LOAD_C. Coefficients load in order a_D first, a_0 last.
  - LOAD_X: Go=1 -> x<=DataIn, go to LOAD_X_WAIT.
  - LOAD_X_WAIT: Go=0 -> INIT.
  - INIT: acc<=coef[D], i<=D-1, Overflow<=0, go to STEP.
  - STEP: full = acc*x + coef[i], computed at 2*WIDTH+1 bits; acc<=full[WIDTH-1:0]; if full>=2^WIDTH then Overflow<=1.
    - If i==0: DataResult<=full[WIDTH-1:0], go to DONE.
    - Else i<=i-1, stay in STEP.
  - DONE: ResultValid=1; Go=1 -> DONE_WAIT.
  - DONE_WAIT: ResultValid=1; Go=0 -> if ReuseCoeffs: LOAD_X; else k<=DEGREE and go to LOAD_C.
- Latency: if Go is first sampled low in LOAD_X_WAIT at cycle t, then INIT at t+1, STEP at t+2..t+1+D, and ResultValid=1 from cycle t+2+D. Default D=2: 4 cycles.
- DataResult changes only on the final STEP edge or on reset. It holds its value through the next load sequence, while ResultValid=0.
- ResultValid drops on the edge leaving DONE_WAIT.
- Overflow clears in INIT and is meaningful whenever ResultValid=1.
- Go and ReuseCoeffs are ignored in INIT and STEP.
- Go high at reset release: captured into a_D on the first post-reset edge, per the capture rule.
- Arithmetic: unsigned only; no saturation; wrap mod 2^WIDTH.
- All outputs are registered or decoded from the state register only; no combinational path from inputs to outputs.

Test Plan:
- Defaults; enter a2=2, a1=3, a0=4, x=3 -> DataResult=31 (0x1F), ResultValid rises exactly 4 cycles after the first Go-low in LOAD_X_WAIT, Overflow=0, Busy high 3 cycles.
- Defaults; a2=16, a1=0, a0=5, x=16 -> step1 full=256 wraps to acc=0; DataResult=5, Overflow=1.
- Continue from previous: press/release Go with ReuseCoeffs=1, then enter x=2 -> LoadIndex=3 during load; DataResult=69, Overflow=0; coefficients not re-entered.
- WIDTH=16, DEGREE=4; coefficients 1,0,0,0,1, x=10 -> DataResult=10001, ResultValid 6 cycles after Go release; LoadIndex sequence 4,3,2,1,0,5.
- Hold Go high 20 cycles in LOAD_C while DataIn changes 7->9 -> only 7 captured; FSM remains in LOAD_C_WAIT until Go low.
- Assert Reset for 1 cycle during STEP -> next cycle state LOAD_C, DataResult=0, ResultValid=0, Busy=0, LoadIndex=DEGREE; a fresh full load gives a correct result.

Source files
------------

// File: rtl/poly_eval_seq.sv
// Sequential polynomial evaluator using Horner's method, one multiply-accumulate
// per clock. Coefficients (a_D first, a_0 last) and then x are entered one value
// per Go press/release on DataIn. The result is held with ResultValid until the
// next load sequence starts.
module poly_eval_seq #(
  parameter int WIDTH  = 8,
  parameter int DEGREE = 2,
  parameter int IDXW   = $clog2(DEGREE + 2)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Go,
  input  logic             ReuseCoeffs,
  input  logic [WIDTH-1:0] DataIn,
  output logic [WIDTH-1:0] DataResult,
  output logic             ResultValid,
  output logic             Overflow,
  output logic             Busy,
  output logic [IDXW-1:0]  LoadIndex
);

  // Width needed to address the D+1 coefficient registers.
  localparam int CIW = $clog2(DEGREE + 1);
  // Wide enough for acc*x + coef without losing the carry out.
  localparam int FW  = 2 * WIDTH + 1;

  typedef enum logic [2:0] {
    S_LOAD_C,
    S_LOAD_C_WAIT,
    S_LOAD_X,
    S_LOAD_X_WAIT,
    S_INIT,
    S_STEP,
    S_DONE,
    S_DONE_WAIT
  } state_t;

  state_t            state, state_nx;
  logic [WIDTH-1:0]  coef [DEGREE+1];
  logic [WIDTH-1:0]  x;
  logic [WIDTH-1:0]  acc;
  logic [IDXW-1:0]   k;
  logic [IDXW-1:0]   i;
  logic [FW-1:0]     full;

  // One Horner step at full precision.
  always_comb begin
    full = FW'(acc) * FW'(x) + FW'(coef[i[CIW-1:0]]);
  end

  // State register.
  always_ff @(posedge Clock) begin
    if (Reset) state <= S_LOAD_C;
    else       state <= state_nx;
  end

  // Next-state logic: each LOAD state captures once, its WAIT state waits for Go low.
  always_comb begin
    state_nx = state;
    case (state)
      S_LOAD_C:      if (Go)  state_nx = S_LOAD_C_WAIT;
      S_LOAD_C_WAIT: if (!Go) state_nx = (k == '0) ? S_LOAD_X : S_LOAD_C;
      S_LOAD_X:      if (Go)  state_nx = S_LOAD_X_WAIT;
      S_LOAD_X_WAIT: if (!Go) state_nx = S_INIT;
      S_INIT:                 state_nx = S_STEP;
      S_STEP:        if (i == '0) state_nx = S_DONE;
      S_DONE:        if (Go)  state_nx = S_DONE_WAIT;
      S_DONE_WAIT:   if (!Go) state_nx = ReuseCoeffs ? S_LOAD_X : S_LOAD_C;
      default:                state_nx = S_LOAD_C;
    endcase
  end

  // Datapath registers: coefficient/x capture, index counters, accumulator, result.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int unsigned n = 0; n < unsigned'(DEGREE + 1); n++) coef[n] <= '0;
      x          <= '0;
      acc        <= '0;
      k          <= IDXW'(DEGREE);
      i          <= '0;
      DataResult <= '0;
      Overflow   <= 1'b0;
    end else begin
      case (state)
        S_LOAD_C: begin
          if (Go) coef[k[CIW-1:0]] <= DataIn;
        end
        S_LOAD_C_WAIT: begin
          if (!Go && k != '0) k <= k - IDXW'(1);
        end
        S_LOAD_X: begin
          if (Go) x <= DataIn;
        end
        S_INIT: begin
          acc      <= coef[DEGREE];
          i        <= IDXW'(DEGREE - 1);
          Overflow <= 1'b0;
        end
        S_STEP: begin
          acc <= full[WIDTH-1:0];
          if (full[FW-1:WIDTH] != '0) Overflow <= 1'b1;
          if (i == '0) DataResult <= full[WIDTH-1:0];
          else         i <= i - IDXW'(1);
        end
        S_DONE_WAIT: begin
          if (!Go && !ReuseCoeffs) k <= IDXW'(DEGREE);
        end
        default: ;
      endcase
    end
  end

  // Status outputs decoded from the state register and load counter only.
  always_comb begin
    ResultValid = 1'b0;
    Busy        = 1'b0;
    LoadIndex   = '0;
    case (state)
      S_LOAD_C, S_LOAD_C_WAIT: LoadIndex   = k;
      S_LOAD_X, S_LOAD_X_WAIT: LoadIndex   = IDXW'(DEGREE + 1);
      S_INIT, S_STEP:          Busy        = 1'b1;
      S_DONE, S_DONE_WAIT:     ResultValid = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_poly_eval_seq.sv
// Bench for poly_eval_seq: a default (8-bit, degree 2) instance and a
// 16-bit degree-4 instance, checked against a sum-of-powers reference model.
module tb_poly_eval_seq;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        ReuseCoeffs;
  logic        go0, go1;
  logic [7:0]  din0;
  logic [15:0] din1;
  logic [7:0]  dr0;
  logic [15:0] dr1;
  logic        rv0, rv1, ovf0, ovf1, busy0, busy1;
  logic [1:0]  li0;
  logic [2:0]  li1;

  int checks = 0;
  int errors = 0;

  always #5 Clock = ~Clock;

  poly_eval_seq dut0 (
    .Clock(Clock), .Reset(Reset), .Go(go0), .ReuseCoeffs(ReuseCoeffs),
    .DataIn(din0), .DataResult(dr0), .ResultValid(rv0), .Overflow(ovf0),
    .Busy(busy0), .LoadIndex(li0)
  );

  poly_eval_seq #(.WIDTH(16), .DEGREE(4)) dut1 (
    .Clock(Clock), .Reset(Reset), .Go(go1), .ReuseCoeffs(ReuseCoeffs),
    .DataIn(din1), .DataResult(dr1), .ResultValid(rv1), .Overflow(ovf1),
    .Busy(busy1), .LoadIndex(li1)
  );

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int deg_of(input int w);  return (w != 0) ? 4 : 2;  endfunction
  function automatic int wid_of(input int w);  return (w != 0) ? 16 : 8; endfunction
  function automatic longint get_dr(input int w);   return (w != 0) ? longint'(dr1) : longint'(dr0); endfunction
  function automatic longint get_rv(input int w);   return (w != 0) ? longint'(rv1) : longint'(rv0); endfunction
  function automatic longint get_ovf(input int w);  return (w != 0) ? longint'(ovf1) : longint'(ovf0); endfunction
  function automatic longint get_busy(input int w); return (w != 0) ? longint'(busy1) : longint'(busy0); endfunction
  function automatic longint get_li(input int w);   return (w != 0) ? longint'(li1) : longint'(li0); endfunction

  task automatic set_go(input int w, input logic v);
    if (w != 0) go1 = v; else go0 = v;
  endtask

  task automatic set_din(input int w, input longint v);
    if (w != 0) din1 = 16'(v); else din0 = 8'(v);
  endtask

  // Reference: y = sum a_k*x^k mod 2^w; overflow if any Horner partial value
  // (before wrapping) reaches 2^w.
  function automatic void model(input int deg, input int w, input longint c[5],
                                input longint xv, output longint y, output bit ovf);
    longint m = longint'(1) << w;
    longint p = 1;
    longint v;
    longint f;
    y = 0;
    for (int kk = 0; kk <= deg; kk++) begin
      y = (y + c[kk] * p) % m;
      p = (p * xv) % m;
    end
    ovf = 1'b0;
    v = c[deg];
    for (int kk = deg - 1; kk >= 0; kk--) begin
      f = v * xv + c[kk];
      if (f >= m) ovf = 1'b1;
      v = f % m;
    end
  endfunction

  task automatic load_one(input int w, input longint v, input int idx);
    chk("load_idx", get_li(w), idx);
    set_din(w, v);
    set_go(w, 1'b1);
    tick();
    chk("load_idx_wait", get_li(w), idx);
    set_go(w, 1'b0);
    tick();
  endtask

  // Loads coefficients from first_k down to 0 (none if first_k<0), then x,
  // then checks latency, busy length, result and overflow.
  task automatic run_poly(input int w, input longint c[5], input longint xv, input int first_k);
    int deg = deg_of(w);
    int lat;
    int busy_cnt;
    longint y;
    bit ovf;
    for (int kk = first_k; kk >= 0; kk--) load_one(w, c[kk], kk);
    chk("x_idx", get_li(w), deg + 1);
    set_din(w, xv);
    set_go(w, 1'b1);
    tick();
    chk("x_idx_wait", get_li(w), deg + 1);
    set_go(w, 1'b0);
    tick();
    lat = 1;
    busy_cnt = 0;
    while (get_rv(w) == 0 && lat < 40) begin
      if (get_busy(w) != 0) busy_cnt++;
      tick();
      lat++;
    end
    model(deg, wid_of(w), c, xv, y, ovf);
    chk("latency", lat, deg + 2);
    chk("busy_len", busy_cnt, deg + 1);
    chk("result", get_dr(w), y);
    chk("overflow", get_ovf(w), longint'(ovf));
    chk("done_idx", get_li(w), 0);
  endtask

  task automatic ack(input int w, input bit reuse);
    longint held = get_dr(w);
    ReuseCoeffs = reuse;
    set_go(w, 1'b1);
    tick();
    chk("dw_valid", get_rv(w), 1);
    set_go(w, 1'b0);
    tick();
    ReuseCoeffs = 1'b0;
    chk("ack_valid", get_rv(w), 0);
    chk("ack_hold", get_dr(w), held);
    chk("ack_idx", get_li(w), reuse ? deg_of(w) + 1 : deg_of(w));
  endtask

  initial begin
    longint c0[5];
    longint c1[5];
    longint xv;
    bit     reuse;

    Reset = 1'b1; ReuseCoeffs = 1'b0;
    go0 = 1'b0; go1 = 1'b0; din0 = '0; din1 = '0;
    repeat (3) tick();
    chk("rst_dr", dr0, 0);
    chk("rst_rv", rv0, 0);
    chk("rst_ovf", ovf0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_idx0", li0, 2);
    chk("rst_idx1", li1, 4);
    Reset = 1'b0;
    tick();

    // Directed: 2x^2+3x+4 at x=3.
    c0 = '{4, 3, 2, 0, 0};
    run_poly(0, c0, 3, 2);
    chk("tp_31", dr0, 31);
    ack(0, 1'b0);

    // Directed: first Horner step wraps to zero.
    c0 = '{5, 0, 16, 0, 0};
    run_poly(0, c0, 16, 2);
    chk("tp_wrap", dr0, 5);
    chk("tp_wrap_ovf", ovf0, 1);
    ack(0, 1'b1);

    // Reuse coefficients with new x.
    run_poly(0, c0, 2, -1);
    chk("tp_69", dr0, 69);
    ack(0, 1'b0);

    // Random polynomials, occasionally reusing coefficients.
    reuse = 1'b0;
    for (int t = 0; t < 6; t++) begin
      if (!reuse) for (int kk = 0; kk < 3; kk++)
        c0[kk] = (t % 2 == 0) ? longint'($urandom_range(0, 7)) : longint'($urandom_range(0, 255));
      xv = (t % 2 == 0) ? longint'($urandom_range(0, 7)) : longint'($urandom_range(0, 255));
      run_poly(0, c0, xv, reuse ? -1 : 2);
      reuse = ($urandom_range(0, 1) == 1);
      ack(0, reuse);
    end
    if (reuse) begin
      run_poly(0, c0, 1, -1);
      ack(0, 1'b0);
    end

    // Wide instance: x^4 + 1 at x=10.
    c1 = '{1, 0, 0, 0, 1};
    run_poly(1, c1, 10, 4);
    chk("tp_10001", dr1, 10001);
    ack(1, 1'b0);
    for (int t = 0; t < 3; t++) begin
      for (int kk = 0; kk < 5; kk++) c1[kk] = longint'($urandom_range(0, 65535));
      xv = longint'($urandom_range(0, 20));
      run_poly(1, c1, xv, 4);
      ack(1, 1'b0);
    end

    // Holding Go captures once: a2 must be 7, not 9.
    din0 = 8'd7;
    go0 = 1'b1;
    repeat (10) tick();
    din0 = 8'd9;
    repeat (10) tick();
    chk("hold_idx", li0, 2);
    chk("hold_busy", busy0, 0);
    go0 = 1'b0;
    tick();
    c0 = '{1, 1, 7, 0, 0};
    run_poly(0, c0, 2, 1);
    chk("hold_val", dr0, 31);
    ack(0, 1'b0);

    // Reset during STEP.
    load_one(0, 3, 2);
    load_one(0, 3, 1);
    load_one(0, 3, 0);
    din0 = 8'd3;
    go0 = 1'b1;
    tick();
    go0 = 1'b0;
    tick();
    tick();
    chk("pre_rst_busy", busy0, 1);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk("mid_rst_dr", dr0, 0);
    chk("mid_rst_rv", rv0, 0);
    chk("mid_rst_busy", busy0, 0);
    chk("mid_rst_ovf", ovf0, 0);
    chk("mid_rst_idx", li0, 2);
    c0 = '{9, 8, 6, 0, 0};
    run_poly(0, c0, 5, 2);
    ack(0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety net so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
